// File: rtl/img_pkg.sv
// Shared definitions for the 3x3 window generator: kernel size,
// pixel type, window element index helper and the fill/stream FSM state.
package img_pkg;

    localparam int K_W   = 3;
    localparam int K_H   = 3;
    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic {
        FILL,
        STREAM
    } win_state_t;

    function automatic int win_idx(input int m, input int n);
        return K_W * m + n;
    endfunction

endpackage

// File: rtl/img_line_buf.sv
// One image row of pixel storage: synchronous write, asynchronous read.
// Ports: clk, we/addr/wdata write port, rdata = mem[addr] (same address).
module img_line_buf
    import img_pkg::*;
#(
    parameter int Depth     = 512,
    parameter int Datawidth = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(Depth)-1:0] addr,
    input  logic [Datawidth-1:0]     wdata,
    output logic [Datawidth-1:0]     rdata
);

    logic [Datawidth-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/img_win_gen.sv
// Streaming 3x3 window generator: raster pixels in, one valid-region
// neighbourhood out per accepted pixel at row>=2, col>=2.
// Ports: clk, reset (async, active-low); in_pix_data/valid/ready input
// stream; win_data/valid/ready output stream with win_sol (first window
// of an output row) and win_eof (last window of the frame).
// Element (m,n) of win_data sits at [(3*m+n)*Datawidth +: Datawidth].
// IMG_WIN_GEN_SKID_EN: adds a 1-entry output skid so in_pix_ready is
// registered; otherwise in_pix_ready = win_ready | ~win_valid.
module img_win_gen
    import img_pkg::*;
#(
    parameter int Datawidth = 8,
    parameter int Img_W     = 512,
    parameter int Img_H     = 512
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [Datawidth-1:0]   in_pix_data,
    input  logic                   in_pix_valid,
    output logic                   in_pix_ready,
    output logic [9*Datawidth-1:0] win_data,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic                   win_sol,
    output logic                   win_eof
);

    localparam int CW = $clog2(Img_W);
    localparam int RW = $clog2(Img_H);
    localparam int CB = K_H * Datawidth;
    localparam int WW = K_W * K_H * Datawidth;

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    win_state_t           state;
    logic [Datawidth-1:0] lb0_rd;
    logic [Datawidth-1:0] lb1_rd;
    // Columns packed with m=0 (oldest row) in the low bits.
    logic [CB-1:0]        col_new;
    logic [CB-1:0]        sr1;
    logic [CB-1:0]        sr2;
    logic                 in_xfer;
    logic                 out_xfer;
    logic                 col_last;
    logic                 row_last;
    logic                 emit;
    logic [WW-1:0]        win_new;
    logic                 sol_new;
    logic                 eof_new;

    assign in_xfer  = in_pix_valid & in_pix_ready;
    assign out_xfer = win_valid & win_ready;
    assign col_last = (col == CW'(Img_W - 1));
    assign row_last = (row == RW'(Img_H - 1));
    assign emit     = in_xfer && (state == STREAM) && (col >= CW'(2));
    assign col_new  = {in_pix_data, lb0_rd, lb1_rd};
    assign sol_new  = (col == CW'(2));
    assign eof_new  = row_last && col_last;

    img_line_buf #(.Depth(Img_W), .Datawidth(Datawidth)) u_lb0 (
        .clk   (clk),
        .we    (in_xfer),
        .addr  (col),
        .wdata (in_pix_data),
        .rdata (lb0_rd)
    );

    img_line_buf #(.Depth(Img_W), .Datawidth(Datawidth)) u_lb1 (
        .clk   (clk),
        .we    (in_xfer),
        .addr  (col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // The rightmost window column is the live input column, so only the
    // two older columns need registers.
    always_comb begin
        win_new = '0;
        for (int m = 0; m < K_H; m++) begin
            win_new[win_idx(m, 0)*Datawidth +: Datawidth] =
                sr1[m*Datawidth +: Datawidth];
            win_new[win_idx(m, 1)*Datawidth +: Datawidth] =
                sr2[m*Datawidth +: Datawidth];
            win_new[win_idx(m, 2)*Datawidth +: Datawidth] =
                col_new[m*Datawidth +: Datawidth];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col   <= '0;
            row   <= '0;
            state <= FILL;
            sr1   <= '0;
            sr2   <= '0;
        end else if (in_xfer) begin
            sr1 <= sr2;
            sr2 <= col_new;
            if (col_last) begin
                col <= '0;
                if (row_last) begin
                    row   <= '0;
                    state <= FILL;
                end else begin
                    row <= row + RW'(1);
                    if (row == RW'(1)) begin
                        state <= STREAM;
                    end
                end
            end else begin
                col <= col + CW'(1);
            end
        end
    end

`ifdef IMG_WIN_GEN_SKID_EN
    logic          sk_valid;
    logic [WW-1:0] sk_data;
    logic          sk_sol;
    logic          sk_eof;

    // A window arriving while the output is stalled parks in the skid
    // entry; ready drops for exactly as long as that entry is full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_valid    <= 1'b0;
            win_data     <= '0;
            win_sol      <= 1'b0;
            win_eof      <= 1'b0;
            sk_valid     <= 1'b0;
            sk_data      <= '0;
            sk_sol       <= 1'b0;
            sk_eof       <= 1'b0;
            in_pix_ready <= 1'b1;
        end else if (win_valid && !out_xfer) begin
            if (emit) begin
                sk_valid     <= 1'b1;
                sk_data      <= win_new;
                sk_sol       <= sol_new;
                sk_eof       <= eof_new;
                in_pix_ready <= 1'b0;
            end
        end else if (sk_valid) begin
            win_valid    <= 1'b1;
            win_data     <= sk_data;
            win_sol      <= sk_sol;
            win_eof      <= sk_eof;
            sk_valid     <= 1'b0;
            in_pix_ready <= 1'b1;
        end else if (emit) begin
            win_valid <= 1'b1;
            win_data  <= win_new;
            win_sol   <= sol_new;
            win_eof   <= eof_new;
        end else begin
            win_valid <= 1'b0;
        end
    end
`else
    assign in_pix_ready = win_ready | ~win_valid;

    // Input is only accepted when the output slot frees this cycle, so a
    // new window can always overwrite the register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_valid <= 1'b0;
            win_data  <= '0;
            win_sol   <= 1'b0;
            win_eof   <= 1'b0;
        end else if (emit) begin
            win_valid <= 1'b1;
            win_data  <= win_new;
            win_sol   <= sol_new;
            win_eof   <= eof_new;
        end else if (out_xfer) begin
            win_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_img_win_gen.sv
// Directed bench for img_win_gen: 5x5 instance for ramp, stall, gaps,
// back-to-back and mid-frame reset; 3x3 instance for the minimum image.
module tb_img_win_gen;
    import img_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    pixel_t      in_data;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] win_data;
    logic        win_valid;
    logic        win_ready;
    logic        win_sol;
    logic        win_eof;

    pixel_t      s_in_data;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [71:0] s_win_data;
    logic        s_win_valid;
    logic        s_win_ready;
    logic        s_win_sol;
    logic        s_win_eof;

    int checks = 0;
    int failures = 0;

    logic [71:0] q_data[$];
    logic        q_sol[$];
    logic        q_eof[$];
    logic [71:0] s_q_data[$];
    logic        s_q_sol[$];
    logic        s_q_eof[$];

    img_win_gen #(.Datawidth(8), .Img_W(5), .Img_H(5)) u_dut5 (
        .clk          (clk),
        .reset        (reset),
        .in_pix_data  (in_data),
        .in_pix_valid (in_valid),
        .in_pix_ready (in_ready),
        .win_data     (win_data),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .win_sol      (win_sol),
        .win_eof      (win_eof)
    );

    img_win_gen #(.Datawidth(8), .Img_W(3), .Img_H(3)) u_dut3 (
        .clk          (clk),
        .reset        (reset),
        .in_pix_data  (s_in_data),
        .in_pix_valid (s_in_valid),
        .in_pix_ready (s_in_ready),
        .win_data     (s_win_data),
        .win_valid    (s_win_valid),
        .win_ready    (s_win_ready),
        .win_sol      (s_win_sol),
        .win_eof      (s_win_eof)
    );

    always @(negedge clk) begin
        if (reset && win_valid && win_ready) begin
            q_data.push_back(win_data);
            q_sol.push_back(win_sol);
            q_eof.push_back(win_eof);
        end
        if (reset && s_win_valid && s_win_ready) begin
            s_q_data.push_back(s_win_data);
            s_q_sol.push_back(s_win_sol);
            s_q_eof.push_back(s_win_eof);
        end
    end

    function automatic logic [71:0] exp_win(input int base, input int w,
                                            input int r, input int c);
        logic [71:0] v;
        v = '0;
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++)
                v[(3*m+n)*8 +: 8] = 8'(base + w*(r-2+m) + (c-2+n));
        return v;
    endfunction

    task automatic clear_q();
        q_data.delete();
        q_sol.delete();
        q_eof.delete();
    endtask

    task automatic feed_pix(input int p, input bit gaps);
        int t;
        bit done;
        if (gaps && $urandom_range(1, 0) == 1) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_data  = pixel_t'(p);
        in_valid = 1'b1;
        done = 1'b0;
        t = 0;
        while (!done && t < 40) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
            t++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL feed_timeout pixel=%0d", p);
        end
    endtask

    task automatic feed_frame(input int base, input bit gaps);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                feed_pix(base + 5*r + c, gaps);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b0; in_data = '0; win_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = '0; s_win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (win_valid !== 1'b0 || win_data !== 72'h0 ||
            win_sol !== 1'b0 || win_eof !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset5 got v=%b d=%h s=%b e=%b rdy=%b exp 0/0/0/0/1",
                     win_valid, win_data, win_sol, win_eof, in_ready);
        end
        checks++;
        if (s_win_valid !== 1'b0 || s_win_data !== 72'h0 ||
            s_win_sol !== 1'b0 || s_win_eof !== 1'b0 || s_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset3 got v=%b d=%h s=%b e=%b rdy=%b exp 0/0/0/0/1",
                     s_win_valid, s_win_data, s_win_sol, s_win_eof, s_in_ready);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp(input string tag);
        clear_q();
        for (int p = 0; p < 12; p++) feed_pix(p, 1'b0);
        checks++;
        if (win_valid !== 1'b0 || q_data.size() != 0) begin
            failures++;
            $display("FAIL %s_early got v=%b n=%0d exp v=0 n=0",
                     tag, win_valid, q_data.size());
        end
        feed_pix(12, 1'b0);
        checks++;
        if (win_valid !== 1'b1 || win_data !== exp_win(0, 5, 2, 2)) begin
            failures++;
            $display("FAIL %s_first got v=%b d=%h exp v=1 d=%h",
                     tag, win_valid, win_data, exp_win(0, 5, 2, 2));
        end
        for (int p = 13; p < 25; p++) feed_pix(p, 1'b0);
        in_valid = 1'b0;
        drain();
        checks++;
        if (q_data.size() != 9) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=9", tag, q_data.size());
        end
        for (int k = 0; k < q_data.size() && k < 9; k++) begin
            checks++;
            if (q_data[k] !== exp_win(0, 5, 2 + k/3, 2 + k%3) ||
                q_sol[k] !== (k%3 == 0) || q_eof[k] !== (k == 8)) begin
                failures++;
                $display("FAIL %s_win%0d got d=%h s=%b e=%b exp d=%h s=%b e=%b",
                         tag, k, q_data[k], q_sol[k], q_eof[k],
                         exp_win(0, 5, 2 + k/3, 2 + k%3), k%3 == 0, k == 8);
            end
        end
    endtask

    task automatic test_stall();
        logic [71:0] held;
        clear_q();
        fork
            feed_frame(0, 1'b0);
            begin
                int t;
                t = 0;
                while (!win_valid && t < 100) begin
                    @(posedge clk); #1;
                    t++;
                end
                checks++;
                if (win_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_wait got v=%b exp v=1", win_valid);
                end
                held = win_data;
                win_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (win_valid !== 1'b1 || win_data !== held) begin
                        failures++;
                        $display("FAIL stall_hold%0d got v=%b d=%h exp v=1 d=%h",
                                 i, win_valid, win_data, held);
                    end
`ifndef IMG_WIN_GEN_SKID_EN
                    checks++;
                    if (in_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_rdy%0d got=%b exp=0", i, in_ready);
                    end
`endif
                end
`ifdef IMG_WIN_GEN_SKID_EN
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_rdy got=%b exp=0", in_ready);
                end
`endif
                win_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (q_data.size() != 9) begin
            failures++;
            $display("FAIL stall_count got=%0d exp=9", q_data.size());
        end
        for (int k = 0; k < q_data.size() && k < 9; k++) begin
            checks++;
            if (q_data[k] !== exp_win(0, 5, 2 + k/3, 2 + k%3) ||
                q_sol[k] !== (k%3 == 0) || q_eof[k] !== (k == 8)) begin
                failures++;
                $display("FAIL stall_win%0d got d=%h s=%b e=%b exp d=%h",
                         k, q_data[k], q_sol[k], q_eof[k],
                         exp_win(0, 5, 2 + k/3, 2 + k%3));
            end
        end
    endtask

    task automatic test_gaps();
        clear_q();
        feed_frame(0, 1'b1);
        drain();
        checks++;
        if (q_data.size() != 9) begin
            failures++;
            $display("FAIL gaps_count got=%0d exp=9", q_data.size());
        end
        for (int k = 0; k < q_data.size() && k < 9; k++) begin
            checks++;
            if (q_data[k] !== exp_win(0, 5, 2 + k/3, 2 + k%3) ||
                q_sol[k] !== (k%3 == 0) || q_eof[k] !== (k == 8)) begin
                failures++;
                $display("FAIL gaps_win%0d got d=%h s=%b e=%b exp d=%h",
                         k, q_data[k], q_sol[k], q_eof[k],
                         exp_win(0, 5, 2 + k/3, 2 + k%3));
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        feed_frame(0, 1'b0);
        feed_frame(100, 1'b0);
        drain();
        checks++;
        if (q_data.size() != 18) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=18", q_data.size());
        end
        for (int k = 0; k < q_data.size() && k < 18; k++) begin
            int b;
            int j;
            b = (k < 9) ? 0 : 100;
            j = k % 9;
            checks++;
            if (q_data[k] !== exp_win(b, 5, 2 + j/3, 2 + j%3) ||
                q_sol[k] !== (j%3 == 0) || q_eof[k] !== (j == 8)) begin
                failures++;
                $display("FAIL b2b_win%0d got d=%h s=%b e=%b exp d=%h",
                         k, q_data[k], q_sol[k], q_eof[k],
                         exp_win(b, 5, 2 + j/3, 2 + j%3));
            end
        end
    endtask

    task automatic test_mid_reset();
        clear_q();
        for (int p = 0; p < 7; p++) feed_pix(p, 1'b0);
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (win_valid !== 1'b0 || win_data !== 72'h0 ||
            win_sol !== 1'b0 || win_eof !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_out got v=%b d=%h s=%b e=%b rdy=%b exp 0/0/0/0/1",
                     win_valid, win_data, win_sol, win_eof, in_ready);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        test_ramp("midrst");
    endtask

    task automatic test_min_size();
        int t;
        bit done;
        s_q_data.delete();
        s_q_sol.delete();
        s_q_eof.delete();
        for (int p = 0; p < 9; p++) begin
            s_in_data = pixel_t'(p);
            s_in_valid = 1'b1;
            done = 1'b0;
            t = 0;
            while (!done && t < 40) begin
                @(negedge clk);
                done = s_in_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!done) begin
                checks++;
                failures++;
                $display("FAIL min_feed_timeout pixel=%0d", p);
            end
        end
        s_in_valid = 1'b0;
        checks++;
        if (s_win_valid !== 1'b1 || s_win_data !== exp_win(0, 3, 2, 2) ||
            s_win_sol !== 1'b1 || s_win_eof !== 1'b1) begin
            failures++;
            $display("FAIL min_win got v=%b d=%h s=%b e=%b exp v=1 d=%h s=1 e=1",
                     s_win_valid, s_win_data, s_win_sol, s_win_eof,
                     exp_win(0, 3, 2, 2));
        end
        drain();
        checks++;
        if (s_q_data.size() != 1) begin
            failures++;
            $display("FAIL min_count got=%0d exp=1", s_q_data.size());
        end
    endtask

    initial begin
        test_reset();
        test_ramp("ramp");
        test_stall();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        test_min_size();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
